// File: rtl/trap_pkg.sv
// Shared definitions for the machine-mode trap unit: CSR map, cause codes,
// CSR operation encodings, FSM states and the interrupt priority helper.
package trap_pkg;

  localparam logic [11:0] CSR_MSTATUS = 12'h300;
  localparam logic [11:0] CSR_MIE     = 12'h304;
  localparam logic [11:0] CSR_MTVEC   = 12'h305;
  localparam logic [11:0] CSR_MEPC    = 12'h341;
  localparam logic [11:0] CSR_MCAUSE  = 12'h342;
  localparam logic [11:0] CSR_MTVAL   = 12'h343;
  localparam logic [11:0] CSR_MIP     = 12'h344;

  localparam logic [4:0] CAUSE_ILLEGAL     = 5'd2;
  localparam logic [4:0] CAUSE_LOAD_FAULT  = 5'd5;
  localparam logic [4:0] CAUSE_STORE_FAULT = 5'd7;
  localparam logic [4:0] CAUSE_ECALL_M     = 5'd11;
  localparam logic [4:0] CAUSE_IRQ_BASE    = 5'd16;

  typedef enum logic [1:0] {
    CSR_OP_NONE  = 2'b00,
    CSR_OP_WRITE = 2'b01,
    CSR_OP_SET   = 2'b10,
    CSR_OP_CLEAR = 2'b11
  } csr_op_e;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_ENTER = 1'b1
  } trap_state_e;

  // Lowest set bit wins, so line 0 has the highest interrupt priority.
  function automatic logic [3:0] lowest_irq(input logic [15:0] pend);
    lowest_irq = 4'd0;
    for (int i = 15; i >= 0; i--) begin
      if (pend[i]) lowest_irq = 4'(i);
    end
  endfunction

endpackage

// File: rtl/trap_csr_file.sv
// Machine-mode CSR storage: read mux, read-modify-write for CSR instructions,
// and the atomic updates performed on trap entry and mret.
module trap_csr_file
  import trap_pkg::*;
#(
  parameter int              XLEN        = 32,
  parameter int              NUM_IRQ     = 4,
  parameter logic [XLEN-1:0] RESET_MTVEC = '0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               csr_we,
  input  logic [1:0]         csr_op,
  input  logic [11:0]        csr_addr,
  input  logic [XLEN-1:0]    csr_wdata,
  output logic [XLEN-1:0]    csr_rdata,
  input  logic [NUM_IRQ-1:0] irq,
  input  logic               trap_enter,
  input  logic [XLEN-1:0]    trap_cause,
  input  logic [XLEN-1:0]    trap_epc,
  input  logic [XLEN-1:0]    trap_tval,
  input  logic               mret_do,
  output logic               irq_pending,
  output logic [NUM_IRQ-1:0] mip,
  output logic [XLEN-1:0]    mtvec,
  output logic [XLEN-1:0]    mepc
);

  logic              st_mie;
  logic              st_mpie;
  logic [1:0]        st_mpp;
  logic [XLEN-1:0]   mie_r;
  logic [XLEN-1:0]   mcause_r;
  logic [XLEN-1:0]   mtval_r;
  logic [XLEN-1:0]   mstatus_val;
  logic [XLEN-1:0]   csr_new;

  assign mstatus_val = XLEN'({st_mpp, 3'b000, st_mpie, 3'b000, st_mie, 3'b000});
  assign irq_pending = st_mie & (|(mip & mie_r[NUM_IRQ-1:0]));

  always_comb begin
    csr_rdata = '0;
    case (csr_addr)
      CSR_MSTATUS: csr_rdata = mstatus_val;
      CSR_MIE:     csr_rdata = mie_r;
      CSR_MTVEC:   csr_rdata = mtvec;
      CSR_MEPC:    csr_rdata = mepc;
      CSR_MCAUSE:  csr_rdata = mcause_r;
      CSR_MTVAL:   csr_rdata = mtval_r;
      CSR_MIP:     csr_rdata = XLEN'(mip);
      default:     csr_rdata = '0;
    endcase
  end

  always_comb begin
    csr_new = csr_rdata;
    case (csr_op_e'(csr_op))
      CSR_OP_WRITE: csr_new = csr_wdata;
      CSR_OP_SET:   csr_new = csr_rdata | csr_wdata;
      CSR_OP_CLEAR: csr_new = csr_rdata & ~csr_wdata;
      default:      csr_new = csr_rdata;
    endcase
  end

  // Trap entry and mret take precedence; the top never asserts csr_we with them.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st_mie   <= 1'b0;
      st_mpie  <= 1'b0;
      st_mpp   <= 2'b11;
      mie_r    <= '0;
      mtvec    <= RESET_MTVEC;
      mepc     <= '0;
      mcause_r <= '0;
      mtval_r  <= '0;
      mip      <= '0;
    end else begin
      mip <= irq;
      if (trap_enter) begin
        mepc     <= trap_epc;
        mcause_r <= trap_cause;
        mtval_r  <= trap_tval;
        st_mpie  <= st_mie;
        st_mie   <= 1'b0;
        st_mpp   <= 2'b11;
      end else if (mret_do) begin
        st_mie  <= st_mpie;
        st_mpie <= 1'b1;
      end else if (csr_we && csr_op != CSR_OP_NONE) begin
        case (csr_addr)
          CSR_MSTATUS: begin
            st_mie  <= csr_new[3];
            st_mpie <= csr_new[7];
            st_mpp  <= csr_new[12:11];
          end
          CSR_MIE:    mie_r    <= csr_new;
          CSR_MTVEC:  mtvec    <= csr_new;
          CSR_MEPC:   mepc     <= csr_new;
          CSR_MCAUSE: mcause_r <= csr_new;
          CSR_MTVAL:  mtval_r  <= csr_new;
          default:    ;
        endcase
      end
    end
  end

endmodule

// File: rtl/trap_unit.sv
// Machine-mode trap controller: prioritises exceptions, interrupts and mret,
// flushes the pipeline and issues a one-cycle redirect to the handler.
module trap_unit
  import trap_pkg::*;
#(
  parameter int              XLEN        = 32,
  parameter int              NUM_IRQ     = 4,
  parameter logic [XLEN-1:0] RESET_MTVEC = '0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               csr_req,
  input  logic [1:0]         csr_op,
  input  logic [11:0]        csr_addr,
  input  logic [XLEN-1:0]    csr_wdata,
  output logic [XLEN-1:0]    csr_rdata,
  input  logic [NUM_IRQ-1:0] irq,
  input  logic               illegal_inst,
  input  logic               ecall_m,
  input  logic               l_fault,
  input  logic               s_fault,
  input  logic               mret,
  input  logic [XLEN-1:0]    epc_cur,
  input  logic [XLEN-1:0]    epc_next,
  input  logic [XLEN-1:0]    fault_addr,
  input  logic [31:0]        inst,
  output logic               flush,
  output logic               regwrite_cancel,
  output logic               redirect_valid,
  output logic [XLEN-1:0]    redirect_pc,
  output logic               busy
);

  trap_state_e        state, state_next;
  logic               exc_any;
  logic               irq_pending;
  logic               take_trap;
  logic               take_mret;
  logic               csr_we;
  logic [NUM_IRQ-1:0] mip;
  logic [XLEN-1:0]    mtvec;
  logic [XLEN-1:0]    mepc;
  logic [3:0]         irq_idx;
  logic [4:0]         irq_code;
  logic [XLEN-1:0]    trap_cause;
  logic [XLEN-1:0]    trap_epc;
  logic [XLEN-1:0]    trap_tval;
  logic [XLEN-1:0]    trap_target;
  logic [XLEN-1:0]    redirect_r;

  assign exc_any  = illegal_inst | ecall_m | s_fault | l_fault;
  assign irq_idx  = lowest_irq(16'(mip));
  assign irq_code = CAUSE_IRQ_BASE + {1'b0, irq_idx};

  always_comb begin
    trap_cause = '0;
    trap_tval  = '0;
    if (illegal_inst) begin
      trap_cause = XLEN'(CAUSE_ILLEGAL);
      trap_tval  = XLEN'(inst);
    end else if (ecall_m) begin
      trap_cause = XLEN'(CAUSE_ECALL_M);
    end else if (s_fault) begin
      trap_cause = XLEN'(CAUSE_STORE_FAULT);
      trap_tval  = fault_addr;
    end else if (l_fault) begin
      trap_cause = XLEN'(CAUSE_LOAD_FAULT);
      trap_tval  = fault_addr;
    end else begin
      trap_cause             = XLEN'(irq_code);
      trap_cause[XLEN-1]     = 1'b1;
    end
  end

  // Vectored offset applies only to interrupts; modes 10/11 behave as direct.
  assign trap_epc    = exc_any ? epc_cur : epc_next;
  assign trap_target = {mtvec[XLEN-1:2], 2'b00}
                     + ((mtvec[1:0] == 2'b01 && !exc_any) ? XLEN'({irq_code, 2'b00}) : '0);

  always_comb begin
    take_trap = 1'b0;
    take_mret = 1'b0;
    if (state == ST_IDLE && !rst) begin
      take_trap = exc_any | irq_pending;
      take_mret = !take_trap & mret;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:  if (take_trap || take_mret) state_next = ST_ENTER;
      ST_ENTER: state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    flush           = take_trap | take_mret;
    regwrite_cancel = take_trap;
    csr_we          = (state == ST_IDLE) & csr_req & ~take_trap & ~take_mret;
    redirect_valid  = (state == ST_ENTER);
    busy            = (state != ST_IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)            redirect_r <= '0;
    else if (take_trap) redirect_r <= trap_target;
    else if (take_mret) redirect_r <= mepc;
  end

  assign redirect_pc = redirect_r;

  trap_csr_file #(
    .XLEN        (XLEN),
    .NUM_IRQ     (NUM_IRQ),
    .RESET_MTVEC (RESET_MTVEC)
  ) u_csr (
    .clk         (clk),
    .rst         (rst),
    .csr_we      (csr_we),
    .csr_op      (csr_op),
    .csr_addr    (csr_addr),
    .csr_wdata   (csr_wdata),
    .csr_rdata   (csr_rdata),
    .irq         (irq),
    .trap_enter  (take_trap),
    .trap_cause  (trap_cause),
    .trap_epc    (trap_epc),
    .trap_tval   (trap_tval),
    .mret_do     (take_mret),
    .irq_pending (irq_pending),
    .mip         (mip),
    .mtvec       (mtvec),
    .mepc        (mepc)
  );

endmodule

// File: tb/tb_trap_unit.sv
// Directed self-checking bench for trap_unit: CSR access, trap entry,
// interrupt vectoring, mret and reset during redirect.
module tb_trap_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        csr_req = 1'b0;
  logic [1:0]  csr_op = 2'b00;
  logic [11:0] csr_addr = 12'h000;
  logic [31:0] csr_wdata = '0;
  logic [31:0] csr_rdata;
  logic [3:0]  irq = '0;
  logic        illegal_inst = 1'b0, ecall_m = 1'b0, l_fault = 1'b0, s_fault = 1'b0, mret = 1'b0;
  logic [31:0] epc_cur = '0, epc_next = '0, fault_addr = '0, inst = '0;
  logic        flush, regwrite_cancel, redirect_valid, busy;
  logic [31:0] redirect_pc;

  int checks = 0;
  int passes = 0;
  logic [31:0] rd;

  trap_unit #(.XLEN(32), .NUM_IRQ(4), .RESET_MTVEC(32'h0)) dut (
    .clk(clk), .rst(rst),
    .csr_req(csr_req), .csr_op(csr_op), .csr_addr(csr_addr),
    .csr_wdata(csr_wdata), .csr_rdata(csr_rdata),
    .irq(irq), .illegal_inst(illegal_inst), .ecall_m(ecall_m),
    .l_fault(l_fault), .s_fault(s_fault), .mret(mret),
    .epc_cur(epc_cur), .epc_next(epc_next), .fault_addr(fault_addr), .inst(inst),
    .flush(flush), .regwrite_cancel(regwrite_cancel),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check_output(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got === exp) passes++;
    else $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic csr_rw(input logic [1:0] op, input logic [11:0] addr,
                        input logic [31:0] wd, output logic [31:0] old);
    csr_req = 1'b1; csr_op = op; csr_addr = addr; csr_wdata = wd;
    #1 old = csr_rdata;
    tick();
    csr_req = 1'b0; csr_op = 2'b00;
  endtask

  task automatic read_csr(input logic [11:0] addr, output logic [31:0] val);
    csr_addr = addr;
    #1 val = csr_rdata;
  endtask

  initial begin
    // Reset behaviour
    #3;
    check_output("rst_busy", {31'b0, busy}, 32'h0);
    check_output("rst_redirect_valid", {31'b0, redirect_valid}, 32'h0);
    illegal_inst = 1'b1;
    #1 check_output("rst_flush", {31'b0, flush}, 32'h0);
    illegal_inst = 1'b0;
    #8 rst = 1'b0;
    read_csr(12'h305, rd); check_output("rst_mtvec", rd, 32'h0);
    read_csr(12'h300, rd); check_output("rst_mstatus", rd, 32'h1800);
    tick();

    // Set then clear on mie returns old values
    csr_rw(2'b10, 12'h304, 32'h5, rd); check_output("csrrs_mie_old", rd, 32'h0);
    csr_rw(2'b11, 12'h304, 32'h1, rd); check_output("csrrc_mie_old", rd, 32'h5);
    read_csr(12'h304, rd); check_output("mie_final", rd, 32'h4);
    read_csr(12'h7C0, rd); check_output("unmapped_read", rd, 32'h0);

    // ecall with direct mtvec
    csr_rw(2'b01, 12'h305, 32'h100, rd);
    csr_rw(2'b10, 12'h300, 32'h8, rd);
    epc_cur = 32'h40; epc_next = 32'h44; ecall_m = 1'b1;
    #1;
    check_output("ecall_flush", {31'b0, flush}, 32'h1);
    check_output("ecall_cancel", {31'b0, regwrite_cancel}, 32'h1);
    tick();
    ecall_m = 1'b0;
    check_output("ecall_redirect_valid", {31'b0, redirect_valid}, 32'h1);
    check_output("ecall_redirect_pc", redirect_pc, 32'h100);
    check_output("ecall_busy", {31'b0, busy}, 32'h1);
    read_csr(12'h341, rd); check_output("ecall_mepc", rd, 32'h40);
    read_csr(12'h342, rd); check_output("ecall_mcause", rd, 32'd11);
    read_csr(12'h300, rd); check_output("ecall_mstatus", rd, 32'h1880);
    tick();
    check_output("ecall_idle_again", {31'b0, busy}, 32'h0);

    // mret restores MIE
    mret = 1'b1;
    #1;
    check_output("mret_flush", {31'b0, flush}, 32'h1);
    check_output("mret_no_cancel", {31'b0, regwrite_cancel}, 32'h0);
    tick();
    mret = 1'b0;
    check_output("mret_redirect_pc", redirect_pc, 32'h40);
    read_csr(12'h300, rd); check_output("mret_mstatus", rd, 32'h1888);
    tick();

    // Vectored interrupt: lowest pending line 1 selected
    csr_rw(2'b01, 12'h305, 32'h101, rd);
    irq = 4'b0110; epc_cur = 32'h40; epc_next = 32'h200;
    #1 check_output("irq_latency_flush", {31'b0, flush}, 32'h0);
    tick();
    check_output("irq_flush", {31'b0, flush}, 32'h1);
    read_csr(12'h344, rd); check_output("mip_read", rd, 32'h6);
    tick();
    irq = 4'b0000;
    check_output("irq_redirect_pc", redirect_pc, 32'h144);
    read_csr(12'h342, rd); check_output("irq_mcause", rd, 32'h80000011);
    read_csr(12'h341, rd); check_output("irq_mepc", rd, 32'h200);
    read_csr(12'h343, rd); check_output("irq_mtval", rd, 32'h0);
    tick();

    // Illegal + load fault + CSR write in one cycle
    inst = 32'hDEADBEEF; fault_addr = 32'h1234;
    illegal_inst = 1'b1; l_fault = 1'b1;
    csr_req = 1'b1; csr_op = 2'b01; csr_addr = 12'h304; csr_wdata = 32'hFF;
    tick();
    illegal_inst = 1'b0; l_fault = 1'b0; csr_req = 1'b0; csr_op = 2'b00;
    read_csr(12'h342, rd); check_output("illegal_mcause", rd, 32'd2);
    read_csr(12'h343, rd); check_output("illegal_mtval", rd, 32'hDEADBEEF);
    read_csr(12'h304, rd); check_output("illegal_csr_kept", rd, 32'h4);
    tick();

    // Store fault outranks load fault
    s_fault = 1'b1; l_fault = 1'b1; fault_addr = 32'h5678;
    tick();
    s_fault = 1'b0; l_fault = 1'b0;
    read_csr(12'h342, rd); check_output("sfault_mcause", rd, 32'd7);
    read_csr(12'h343, rd); check_output("sfault_mtval", rd, 32'h5678);
    tick();

    // mtvec mode 10 behaves as direct
    csr_rw(2'b01, 12'h304, 32'h1, rd);
    csr_rw(2'b01, 12'h305, 32'h102, rd);
    csr_rw(2'b10, 12'h300, 32'h8, rd);
    irq = 4'b0001;
    tick();
    tick();
    irq = 4'b0000;
    check_output("mode10_redirect_pc", redirect_pc, 32'h100);
    read_csr(12'h342, rd); check_output("mode10_mcause", rd, 32'h80000010);
    tick();

    // Reset in the middle of a redirect
    ecall_m = 1'b1;
    tick();
    ecall_m = 1'b0;
    check_output("pre_rst_redirect_valid", {31'b0, redirect_valid}, 32'h1);
    rst = 1'b1;
    #1;
    check_output("mid_rst_redirect_valid", {31'b0, redirect_valid}, 32'h0);
    check_output("mid_rst_busy", {31'b0, busy}, 32'h0);
    read_csr(12'h305, rd); check_output("mid_rst_mtvec", rd, 32'h0);
    #2 rst = 1'b0;
    tick();
    check_output("post_rst_busy", {31'b0, busy}, 32'h0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/trap_unit.md
TRAP_UNIT -- requirements
Module: trap_unit

Interface
REQ-001 SHALL have parameter XLEN, 32, datapath/CSR width.
REQ-002 SHALL have parameter NUM_IRQ, 4, local interrupt lines (1..16).
REQ-003 SHALL have parameter RESET_MTVEC, 0, mtvec reset value.
REQ-004 SHALL have port clk  in  1  clock; rst  in  1  reset, asynchronous, active-high.
REQ-005 SHALL have csr_req  in  1  CSR instruction valid at MEM; csr_op  in  2  01 write/10 set/11 clear; csr_addr  in  12; csr_wdata  in  XLEN  (reg or zero-extended zimm); csr_rdata  out  XLEN.
REQ-006 SHALL have irq  in  NUM_IRQ  level interrupts; illegal_inst, ecall_m, l_fault, s_fault, mret  in  1 each.
REQ-007 SHALL have epc_cur  in  XLEN  faulting PC; epc_next  in  XLEN  oldest unflushed PC; fault_addr  in  XLEN; inst  in  32.
REQ-008 SHALL have flush  out  1  all pipeline regs; regwrite_cancel  out  1; redirect_valid  out  1; redirect_pc  out  XLEN; busy  out  1.

Function
REQ-009 SHALL implement mstatus(0x300: MIE[3], MPIE[7], MPP[12:11]), mie(0x304), mtvec(0x305), mepc(0x341), mcause(0x342), mtval(0x343), mip(0x344, read-only); others read 0, writes ignored.
REQ-010 SHALL return old CSR value combinationally on csr_rdata; update at clock edge: write=wdata, set=old|wdata, clear=old&~wdata.
REQ-011 SHALL register irq into mip every cycle (1-cycle latency); interrupt pending = MIE & |(mip&mie).
REQ-012 SHALL prioritise exceptions: illegal_inst(2) > ecall_m(11) > s_fault(7) > l_fault(5) > interrupt > mret > csr_req.
REQ-013 SHALL select lowest-index pending irq i; mcause = {1, code 16+i}.
REQ-014 SHALL, in IDLE on trap, assert flush and regwrite_cancel combinationally same cycle, suppress any CSR write, go to ENTER.
REQ-015 SHALL, at that edge, atomically write mepc (exception: epc_cur; interrupt: epc_next), mcause, mtval (faults: fault_addr; illegal: inst; else 0), MPIE<=MIE, MIE<=0, MPP<=11.
REQ-016 SHALL in ENTER drive redirect_valid=1 one cycle, redirect_pc = {mtvec[XLEN-1:2],00} + (mtvec[1:0]==01 && interrupt ? 4*code : 0), then return to IDLE.
REQ-017 SHALL on mret in IDLE assert flush, MIE<=MPIE, MPIE<=1, go to ENTER with redirect_pc=mepc.
REQ-018 SHALL hold busy=1 outside IDLE and ignore exceptions, mret, csr_req there; level irq stays pending.
REQ-019 SHALL ignore mtvec[1:0] values 10/11 as direct mode.
REQ-020 SHALL compute addresses modulo 2^XLEN.

Reset
REQ-021 SHALL on rst clear all CSRs except mtvec=RESET_MTVEC, MPP=11; state IDLE.
REQ-022 SHALL drive flush, regwrite_cancel, redirect_valid, busy low during/after reset; rst mid-ENTER aborts redirect.

Structure
REQ-023 SHALL place CSR addresses, cause codes, csr_op encodings, state enum in package trap_pkg.
REQ-024 SHALL isolate CSR storage/read-modify-write in sub-module trap_csr_file.

Verification
REQ-025 mtvec=0x100, ecall_m, epc_cur=0x40 -> flush same cycle; next cycle redirect 0x100; mepc=0x40, mcause=11, MIE=0.
REQ-026 mtvec=0x101, MIE=1, mie=0x4, irq=0b0110 -> mcause=0x80000011, redirect 0x144, mepc=epc_next.
REQ-027 illegal_inst and l_fault and csr_req write same cycle -> mcause=2, mtval=inst, CSR unchanged.
REQ-028 after trap, mret -> redirect to mepc, MIE restored 1, MPIE=1.
REQ-029 csrrs 0x304 wdata=0x5 then csrrc wdata=0x1 -> reads 0x0 then 0x5; final mie=0x4.
REQ-030 rst asserted during ENTER -> redirect_valid 0, state IDLE, mtvec=RESET_MTVEC.
